// File: rtl/avalon_arb_pkg.sv
// -----------------------------------------------------------------------------
// avalon_arb_pkg
// Shared definitions for the two-master Avalon-MM arbiter:
//   arb_state_t       - arbiter FSM states
//   MASTER0/MASTER1   - encodings of the grant / round-robin pointer
//   SLAVE_RD_LATENCY  - fixed read latency of the attached slave (cycles)
// -----------------------------------------------------------------------------
package avalon_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RDWAIT  = 2'd2,
      CAPTURE = 2'd3
   } arb_state_t;

   localparam logic MASTER0 = 1'b0;
   localparam logic MASTER1 = 1'b1;

   localparam int SLAVE_RD_LATENCY = 1;

endpackage

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Combinational 2-way round-robin picker.
// Ports:
//   i_req[1:0]  request vector, bit N = master N requesting
//   i_rr_ptr    master preferred when both request
//   o_grant     picked master (only meaningful when |i_req)
// -----------------------------------------------------------------------------
module arb_rr2
   import avalon_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_rr_ptr,
   output logic       o_grant
);

   always_comb begin
      o_grant = MASTER0;
      case (i_req)
         2'b10:   o_grant = MASTER1;
         2'b11:   o_grant = i_rr_ptr;
         default: o_grant = MASTER0;
      endcase
   end

endmodule

// File: rtl/avalon_mm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_mm_rr_arbiter
// Two-master arbiter in front of one Avalon-MM slave with fixed read latency 1.
// Serializes commands, drives registered slave strobes, captures the slave's
// readdata and returns it to the granted master with a one-cycle valid pulse.
//
// Ports:
//   clock, reset                  clock / synchronous active-high reset
//   mN_read, mN_write             master N command strobes (held until accept)
//   mN_address, mN_writedata      master N command payload
//   mN_waitrequest                low only in master N's accept (ISSUE) cycle
//   mN_readdata, mN_readdatavalid returned read data (registered) and pulse
//   s_chipselect/address/write/read/writedata   registered slave command
//   s_readdata                    slave data, valid the cycle after s_read
//
// Build option: ARB_FIXED_PRIORITY_EN - when defined, master 0 always wins
// contention and no round-robin pointer is kept.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; winner's command is latched on exit
// ISSUE   | command visible to slave; granted master sees waitrequest=0
// RDWAIT  | slave readdata valid; captured into granted master's readdata
// CAPTURE | granted master's readdatavalid pulses
// -----------------------------------------------------------------------------
module avalon_mm_rr_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic              s_chipselect,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_write,
   output logic              s_read,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_grant;
   logic              w_pick;
   logic              w_rr_ptr;
   logic [1:0]        w_req;
   logic              w_win_rd;
   logic              w_win_wr;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;

   logic              r_s_cs;
   logic              r_s_wr;
   logic              r_s_rd;
   logic [ADDR_W-1:0] r_s_addr;
   logic [DATA_W-1:0] r_s_wdata;
   logic [DATA_W-1:0] r_m0_rdata;
   logic [DATA_W-1:0] r_m1_rdata;

   assign w_req = {m1_read | m1_write, m0_read | m0_write};

`ifdef ARB_FIXED_PRIORITY_EN
   assign w_rr_ptr = MASTER0;
`else
   logic r_rr_ptr;

   // Pointer moves only when a command is actually accepted.
   always_ff @(posedge clock) begin
      if (reset)
         r_rr_ptr <= MASTER0;
      else if (r_state == ISSUE)
         r_rr_ptr <= ~r_grant;
   end

   assign w_rr_ptr = r_rr_ptr;
`endif

   arb_rr2 u_pick (
      .i_req    (w_req),
      .i_rr_ptr (w_rr_ptr),
      .o_grant  (w_pick)
   );

   assign w_win_wr    = (w_pick == MASTER1) ? m1_write     : m0_write;
   assign w_win_rd    = (w_pick == MASTER1) ? m1_read      : m0_read;
   assign w_win_addr  = (w_pick == MASTER1) ? m1_address   : m0_address;
   assign w_win_wdata = (w_pick == MASTER1) ? m1_writedata : m0_writedata;

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      m0_waitrequest   = 1'b1;
      m1_waitrequest   = 1'b1;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_req)
               w_state_nxt = ISSUE;
         end
         ISSUE: begin
            if (r_grant == MASTER0)
               m0_waitrequest = 1'b0;
            else
               m1_waitrequest = 1'b0;
            w_state_nxt = r_s_rd ? RDWAIT : IDLE;
         end
         RDWAIT: begin
            w_state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (r_grant == MASTER0)
               m0_readdatavalid = 1'b1;
            else
               m1_readdatavalid = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_grant    <= MASTER0;
         r_s_cs     <= 1'b0;
         r_s_wr     <= 1'b0;
         r_s_rd     <= 1'b0;
         r_s_addr   <= '0;
         r_s_wdata  <= '0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_req) begin
                  r_grant   <= w_pick;
                  r_s_cs    <= 1'b1;
                  r_s_addr  <= w_win_addr;
                  r_s_wdata <= w_win_wdata;
                  r_s_wr    <= w_win_wr;
                  // read+write together is treated as a write
                  r_s_rd    <= w_win_rd & ~w_win_wr;
               end
            end
            ISSUE: begin
               r_s_cs    <= 1'b0;
               r_s_wr    <= 1'b0;
               r_s_rd    <= 1'b0;
               r_s_addr  <= '0;
               r_s_wdata <= '0;
            end
            RDWAIT: begin
               if (r_grant == MASTER0)
                  r_m0_rdata <= s_readdata;
               else
                  r_m1_rdata <= s_readdata;
            end
            default: begin
            end
         endcase
      end
   end

   assign s_chipselect = r_s_cs;
   assign s_address    = r_s_addr;
   assign s_write      = r_s_wr;
   assign s_read       = r_s_rd;
   assign s_writedata  = r_s_wdata;
   assign m0_readdata  = r_m0_rdata;
   assign m1_readdata  = r_m1_rdata;

endmodule

// File: tb/tb_avalon_mm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_mm_rr_arbiter
// Self-checking bench: directed scenarios plus a randomized run compared to a
// transaction-timing reference model. Includes a behavioural slave with
// registered readdata (latency 1). Honours ARB_FIXED_PRIORITY_EN.
// -----------------------------------------------------------------------------
module tb_avalon_mm_rr_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [2:0]  m0_address, m1_address;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_chipselect, s_write, s_read;
   logic [2:0]  s_address;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   avalon_mm_rr_arbiter #(.ADDR_W(3), .DATA_W(32)) dut (
      .clock            (clock),
      .reset            (reset),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_address       (m0_address),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_address       (m1_address),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_chipselect     (s_chipselect),
      .s_address        (s_address),
      .s_write          (s_write),
      .s_read           (s_read),
      .s_writedata      (s_writedata),
      .s_readdata       (s_readdata)
   );

   // behavioural slave: registered readdata, cleared on reset
   logic [31:0] smem [8];
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) smem[i] <= '0;
         s_readdata <= '0;
      end else if (s_chipselect) begin
         if (s_write) smem[s_address] <= s_writedata;
         if (s_read)  s_readdata <= smem[s_address];
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_idle();
      m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m0_write = 1; m0_address = 3'd5; m0_writedata = 32'h11112222;
      m1_read  = 1; m1_address = 3'd6;
      tick();
      tick();
      checks++;
      if ({s_chipselect, s_write, s_read, s_address} !== 6'b0) begin
         failures++;
         $display("FAIL reset_s_ctrl: got %b expected 000000", {s_chipselect, s_write, s_read, s_address});
      end
      checks++;
      if (s_writedata !== 32'h0) begin
         failures++;
         $display("FAIL reset_s_wdata: got %h expected 00000000", s_writedata);
      end
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
         failures++;
         $display("FAIL reset_waitreq: got %b expected 11", {m0_waitrequest, m1_waitrequest});
      end
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
         failures++;
         $display("FAIL reset_rdv: got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
      end
      checks++;
      if ({m0_readdata, m1_readdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 0", {m0_readdata, m1_readdata});
      end
      drive_idle();
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      drive_idle();
      m0_write = 1; m0_address = 3'd0; m0_writedata = 32'h12345678;
      tick(); // t+1
      checks++;
      if ({s_chipselect, s_write, s_read, s_address} !== 6'b110000) begin
         failures++;
         $display("FAIL wr_cmd: got %b expected 110000", {s_chipselect, s_write, s_read, s_address});
      end
      checks++;
      if (s_writedata !== 32'h12345678) begin
         failures++;
         $display("FAIL wr_data: got %h expected 12345678", s_writedata);
      end
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
         failures++;
         $display("FAIL wr_waitreq_t1: got %b expected 01", {m0_waitrequest, m1_waitrequest});
      end
      drive_idle();
      m1_write = 1; m1_address = 3'd3; m1_writedata = 32'h0BADBEEF;
      tick(); // t+2, back in IDLE
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_chipselect, s_write} !== 4'b1100) begin
         failures++;
         $display("FAIL wr_t2: got %b expected 1100", {m0_waitrequest, m1_waitrequest, s_chipselect, s_write});
      end
      tick(); // t+3, m1 accepted because t+2 was IDLE
      checks++;
      if ({m1_waitrequest, s_chipselect, s_address} !== 5'b01011) begin
         failures++;
         $display("FAIL wr_idle_at_t2: got %b expected 01011", {m1_waitrequest, s_chipselect, s_address});
      end
      drive_idle();
      tick();
      checks++;
      if (smem[0] !== 32'h12345678) begin
         failures++;
         $display("FAIL wr_slave_mem: got %h expected 12345678", smem[0]);
      end
   endtask

   task automatic test_single_read();
      drive_idle();
      m0_write = 1; m0_address = 3'd2; m0_writedata = 32'hCAFEF00D;
      tick();
      checks++;
      if (m0_waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL rd_preload_accept: got %b expected 0", m0_waitrequest);
      end
      drive_idle();
      tick();
      m1_read = 1; m1_address = 3'd2; // cycle t
      tick(); // t+1
      checks++;
      if ({m1_waitrequest, s_chipselect, s_read, s_write, s_address} !== 7'b0110010) begin
         failures++;
         $display("FAIL rd_cmd: got %b expected 0110010", {m1_waitrequest, s_chipselect, s_read, s_write, s_address});
      end
      drive_idle();
      tick(); // t+2
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, m1_waitrequest, s_chipselect} !== 4'b0010) begin
         failures++;
         $display("FAIL rd_t2: got %b expected 0010", {m0_readdatavalid, m1_readdatavalid, m1_waitrequest, s_chipselect});
      end
      tick(); // t+3
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) begin
         failures++;
         $display("FAIL rd_rdv_t3: got %b expected 01", {m0_readdatavalid, m1_readdatavalid});
      end
      checks++;
      if (m1_readdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL rd_data: got %h expected cafef00d", m1_readdata);
      end
      tick(); // t+4
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00 || m1_readdata !== 32'hCAFEF00D || m0_readdata !== 32'h0) begin
         failures++;
         $display("FAIL rd_hold: rdv=%b m1_rd=%h m0_rd=%h expected 00 cafef00d 0",
                  {m0_readdatavalid, m1_readdatavalid}, m1_readdata, m0_readdata);
      end
   endtask

   task automatic test_rw_both();
      drive_idle();
      m0_read = 1; m0_write = 1; m0_address = 3'd1; m0_writedata = 32'hA5A55A5A;
      tick();
      checks++;
      if ({m0_waitrequest, s_chipselect, s_write, s_read, s_address} !== 7'b0110001) begin
         failures++;
         $display("FAIL rw_cmd: got %b expected 0110001", {m0_waitrequest, s_chipselect, s_write, s_read, s_address});
      end
      drive_idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            failures++;
            $display("FAIL rw_no_rdv: cycle %0d got %b expected 00", i, {m0_readdatavalid, m1_readdatavalid});
         end
      end
      checks++;
      if (smem[1] !== 32'hA5A55A5A) begin
         failures++;
         $display("FAIL rw_slave_mem: got %h expected a5a55a5a", smem[1]);
      end
   endtask

   task automatic test_reset_rdwait();
      drive_idle();
      m1_read = 1; m1_address = 3'd1;
      tick(); // ISSUE
      checks++;
      if (m1_waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL rst_rd_accept: got %b expected 0", m1_waitrequest);
      end
      drive_idle();
      tick(); // RDWAIT
      reset = 1'b1;
      tick();
      checks++;
      if ({s_chipselect, s_write, s_read, s_address, m0_waitrequest, m1_waitrequest,
           m0_readdatavalid, m1_readdatavalid} !== 10'b0000001100) begin
         failures++;
         $display("FAIL rst_rdwait_ctrl: got %b expected 0000001100",
                  {s_chipselect, s_write, s_read, s_address, m0_waitrequest, m1_waitrequest,
                   m0_readdatavalid, m1_readdatavalid});
      end
      checks++;
      if ({m0_readdata, m1_readdata} !== 64'h0) begin
         failures++;
         $display("FAIL rst_rdwait_rdata: got %h expected 0", {m0_readdata, m1_readdata});
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({m0_readdatavalid, m1_readdatavalid, m1_waitrequest} !== 3'b001) begin
            failures++;
            $display("FAIL rst_rdwait_after: cycle %0d got %b expected 001", i,
                     {m0_readdatavalid, m1_readdatavalid, m1_waitrequest});
         end
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_wq;
      logic [2:0] exp_addr;
      do_reset();
      m0_write = 1; m0_address = 3'd0; m0_writedata = 32'h00000001;
      m1_write = 1; m1_address = 3'd1; m1_writedata = 32'h00000002;
      tick();
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_address} !== 5'b01000) begin
         failures++;
         $display("FAIL cont_first: got %b expected 01000", {m0_waitrequest, m1_waitrequest, s_address});
      end
      tick(); // IDLE, both still requesting
      m0_writedata = 32'h00000003;
      tick();
`ifdef ARB_FIXED_PRIORITY_EN
      exp_wq = 2'b01; exp_addr = 3'd0;
`else
      exp_wq = 2'b10; exp_addr = 3'd1;
`endif
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_address} !== {exp_wq, exp_addr}) begin
         failures++;
         $display("FAIL cont_second: got %b expected %b", {m0_waitrequest, m1_waitrequest, s_address}, {exp_wq, exp_addr});
      end
      drive_idle();
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int order[$];
      int last[2];
      int cnt[2];
      int m;
      int exp_space;
      last[0] = -1; last[1] = -1; cnt[0] = 0; cnt[1] = 0;
`ifdef ARB_FIXED_PRIORITY_EN
      exp_space = 2;
`else
      exp_space = 4;
`endif
      do_reset();
      m0_write = 1; m0_address = 3'd0; m0_writedata = 32'h10000000;
      m1_write = 1; m1_address = 3'd1; m1_writedata = 32'h10000001;
      for (int cyc = 0; cyc < 48; cyc++) begin
         tick();
         if (!m0_waitrequest && !m1_waitrequest) begin
            checks++;
            failures++;
            $display("FAIL b2b_double_accept: cycle %0d both waitrequest low, expected at most one", cyc);
         end else if (!m0_waitrequest || !m1_waitrequest) begin
            m = m1_waitrequest ? 0 : 1;
            checks++;
            if ({s_chipselect, s_write, s_address} !== {2'b11, 3'(m)} || s_writedata !== (32'h10000000 + 32'(m))) begin
               failures++;
               $display("FAIL b2b_cmd: master %0d got cs/wr/addr=%b data=%h", m,
                        {s_chipselect, s_write, s_address}, s_writedata);
            end
            if (last[m] >= 0) begin
               checks++;
               if (cyc - last[m] != exp_space) begin
                  failures++;
                  $display("FAIL b2b_spacing: master %0d got %0d expected %0d", m, cyc - last[m], exp_space);
               end
            end
            if (order.size() > 0) begin
               checks++;
`ifdef ARB_FIXED_PRIORITY_EN
               if (m != 0) begin
`else
               if (m == order[order.size()-1]) begin
`endif
                  failures++;
                  $display("FAIL b2b_order: accept %0d got master %0d after master %0d",
                           order.size(), m, order[order.size()-1]);
               end
            end
            order.push_back(m);
            last[m] = cyc;
            cnt[m]++;
         end
      end
      checks++;
      if (order.size() == 0 || order[0] != 0) begin
         failures++;
         $display("FAIL b2b_first: got %0d accepts, first master expected 0", order.size());
      end
      checks++;
`ifdef ARB_FIXED_PRIORITY_EN
      if (cnt[1] != 0 || cnt[0] < 20) begin
         failures++;
         $display("FAIL b2b_counts: got m0=%0d m1=%0d expected m0>=20 m1=0", cnt[0], cnt[1]);
      end
`else
      if (cnt[0] < 10 || cnt[1] < 10) begin
         failures++;
         $display("FAIL b2b_counts: got m0=%0d m1=%0d expected both >=10", cnt[0], cnt[1]);
      end
`endif
      drive_idle();
      tick();
      tick();
   endtask

   // Reference model works in transactions: when the arbiter is free and
   // something is requested, predict who is accepted next cycle, what the
   // slave sees, when the arbiter is free again and when read data returns.
   task automatic test_random();
      logic [31:0] ref_mem [8];
      logic [31:0] exp_rd [2];
      bit          pend [2];
      bit          rel [2];
      bit          cr [2];
      bit          cw [2];
      logic [2:0]  ca [2];
      logic [31:0] cd [2];
      logic        wq [2];
      logic        rv [2];
      logic [31:0] rd [2];
      logic        e_w, e_v;
      int          free_at, acc_cyc, rdv_cyc, acc_m, rdv_m, rr, w, kind;
      bit          acc_w;
      logic [2:0]  acc_a;
      logic [31:0] acc_d, rdv_d;

      do_reset();
      for (int i = 0; i < 8; i++) ref_mem[i] = '0;
      for (int i = 0; i < 2; i++) begin
         exp_rd[i] = '0; pend[i] = 0; rel[i] = 0; cr[i] = 0; cw[i] = 0; ca[i] = '0; cd[i] = '0;
      end
      free_at = 0; acc_cyc = -1; rdv_cyc = -1; acc_m = 0; rdv_m = 0; rr = 0;
      acc_w = 0; acc_a = '0; acc_d = '0; rdv_d = '0;

      for (int k = 0; k < 600; k++) begin
         wq[0] = m0_waitrequest;   wq[1] = m1_waitrequest;
         rv[0] = m0_readdatavalid; rv[1] = m1_readdatavalid;
         rd[0] = m0_readdata;      rd[1] = m1_readdata;
         for (int m = 0; m < 2; m++) begin
            if (rdv_cyc == k && rdv_m == m) exp_rd[m] = rdv_d;
            e_w = !(acc_cyc == k && acc_m == m);
            e_v = (rdv_cyc == k && rdv_m == m);
            checks++;
            if (wq[m] !== e_w) begin
               failures++;
               $display("FAIL rnd_waitreq: cycle %0d m%0d got %b expected %b", k, m, wq[m], e_w);
            end
            checks++;
            if (rv[m] !== e_v) begin
               failures++;
               $display("FAIL rnd_rdv: cycle %0d m%0d got %b expected %b", k, m, rv[m], e_v);
            end
            checks++;
            if (rd[m] !== exp_rd[m]) begin
               failures++;
               $display("FAIL rnd_rdata: cycle %0d m%0d got %h expected %h", k, m, rd[m], exp_rd[m]);
            end
         end
         if (acc_cyc == k) begin
            checks++;
            if ({s_chipselect, s_write, s_read, s_address} !== {1'b1, acc_w, !acc_w, acc_a}) begin
               failures++;
               $display("FAIL rnd_s_cmd: cycle %0d got %b expected %b", k,
                        {s_chipselect, s_write, s_read, s_address}, {1'b1, acc_w, !acc_w, acc_a});
            end
            if (acc_w) begin
               checks++;
               if (s_writedata !== acc_d) begin
                  failures++;
                  $display("FAIL rnd_s_wdata: cycle %0d got %h expected %h", k, s_writedata, acc_d);
               end
            end
         end else begin
            checks++;
            if ({s_chipselect, s_write, s_read} !== 3'b000) begin
               failures++;
               $display("FAIL rnd_s_idle: cycle %0d got %b expected 000", k, {s_chipselect, s_write, s_read});
            end
         end

         for (int m = 0; m < 2; m++) begin
            if (rel[m]) begin
               pend[m] = 0;
               rel[m]  = 0;
            end
            if (pend[m] && !wq[m]) begin
               rel[m] = 1;
            end else if (!pend[m] && $urandom_range(0, 1) == 1) begin
               kind    = $urandom_range(0, 3);
               pend[m] = 1;
               cw[m]   = (kind == 1 || kind == 2);
               cr[m]   = (kind != 1);
               ca[m]   = 3'($urandom_range(0, 7));
               cd[m]   = $urandom;
            end
         end
         m0_read = pend[0] & cr[0]; m0_write = pend[0] & cw[0];
         m0_address = ca[0]; m0_writedata = cd[0];
         m1_read = pend[1] & cr[1]; m1_write = pend[1] & cw[1];
         m1_address = ca[1]; m1_writedata = cd[1];

         if (k >= free_at && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
               w = 0;
`else
               w = rr;
`endif
            end else begin
               w = pend[1] ? 1 : 0;
            end
            acc_cyc = k + 1;
            acc_m   = w;
            acc_w   = cw[w];
            acc_a   = ca[w];
            acc_d   = cd[w];
            if (acc_w) begin
               ref_mem[acc_a] = acc_d;
               free_at = k + 2;
            end else begin
               rdv_cyc = k + 3;
               rdv_m   = w;
               rdv_d   = ref_mem[acc_a];
               free_at = k + 4;
            end
            rr = 1 - w;
         end
         tick();
      end
      drive_idle();
      tick();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_single_write();
      test_single_read();
      test_rw_both();
      test_reset_rdwait();
      test_contention();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule

// File: doc/avalon_mm_rr_arbiter.md
Name: avalon_mm_rr_arbiter

Overview:
Two-master round-robin arbiter sharing one Avalon-MM slave port, i.e. the memory-mapped register slave of the 7-segment display IP. It serializes read/write commands from two requesters, for example the CPU bridge and a debug/DMA master. It drives the slave's chipselect/address/write/read/writedata, captures the slave's registered readdata (fixed read latency 1), and returns it to the granted master with a readdatavalid pulse.

Parameters:
ADDR_W, 3, address width on masters and slave
DATA_W, 32, data width on all data buses

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
m0_read  in  1  master 0 read request, held until accepted
m0_write  in  1  master 0 write request, held until accepted
m0_address  in  ADDR_W  master 0 address
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  0 only in master 0's accept cycle
m0_readdata  out  DATA_W  master 0 returned read data (registered)
m0_readdatavalid  out  1  1-cycle pulse, m0_readdata valid
m1_*  same set as m0_*, for master 1
s_chipselect  out  1  slave select (registered)
s_address  out  ADDR_W  slave address (registered)
s_write  out  1  slave write strobe (registered)
s_read  out  1  slave read strobe (registered)
s_writedata  out  DATA_W  slave write data (registered)
s_readdata  in  DATA_W  slave read data; valid the cycle after s_read is presented

Behaviour:
- Reset (sync, active-high): state=IDLE, rr_ptr=0 (master 0 preferred), grant=0. All s_* outputs 0. mN_readdata 0. mN_readdatavalid 0. mN_waitrequest 1.
- FSM states: IDLE, ISSUE, RDWAIT, CAPTURE.
- IDLE: reqN = mN_read|mN_write. If no reqN, stay in IDLE. If only one reqN, that master wins. If both, the master indicated by rr_ptr wins.
- On a win: latch grant; register s_chipselect=1, s_address, s_writedata, and s_write/s_read from the winner; go to ISSUE.
- If a master asserts both read and write, it is treated as a write (s_read=0).
- ISSUE (command visible to slave this cycle): granted mN_waitrequest=0 (combinational from state and grant). rr_ptr <= ~grant. All s_* cleared at the end of this cycle. Next state is IDLE for a write, RDWAIT for a read.
- RDWAIT: slave readdata is valid during this cycle; capture s_readdata into mN_readdata of the granted master; go to CAPTURE.
- CAPTURE: granted mN_readdatavalid=1 for exactly this cycle; the other master's readdatavalid stays 0; go to IDLE.
- Timing, request first seen in IDLE at cycle t:
  - waitrequest low at t+1.
  - Read data valid on the slave at t+2.
  - mN_readdatavalid at t+3.
  - Throughput: one write per 2 cycles, one read per 4 cycles. No overlapping transactions.
- Non-granted master always sees waitrequest=1. Waitrequest is also 1 in IDLE, RDWAIT and CAPTURE.
- Masters must hold their command stable while waitrequest=1. A request withdrawn before acceptance but after winning in IDLE is still issued (protocol violation; not guarded).
- rr_ptr updates only on accept. Back-to-back requests from both masters alternate strictly: 0,1,0,1...
- mN_readdata holds its last captured value until the next read for that master.
- Reset asserted in any state returns to reset values on the next edge. An in-flight transaction is dropped: no waitrequest release, no readdatavalid.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: master 0 always wins contention; rr_ptr is not implemented. Master 1 can starve.
- Undefined: round-robin as described above.

Decomposition:
- Shared package avalon_arb_pkg holds:
  - state enum (IDLE, ISSUE, RDWAIT, CAPTURE);
  - localparams MASTER0=1'b0 and MASTER1=1'b1;
  - localparam SLAVE_RD_LATENCY=1.
- One natural sub-module, arb_rr2: combinational 2-way round-robin picker taking req[1:0] and rr_ptr, producing grant.

Test Plan:
1. Reset, then m0 writes 0x12345678 to addr 0 → s_write=1, s_chipselect=1, s_address=0 at t+1; m0_waitrequest=0 at t+1 only; returns to IDLE at t+2.
2. m1 reads addr 2 while the slave returns 0xCAFEF00D → m1_readdatavalid pulse at t+3, m1_readdata=0xCAFEF00D; m0_readdatavalid stays 0.
3. Both masters continuously write (m0 addr 0, m1 addr 1) → slave sees 0,1,0,1 accept order; each master accepted every 4 cycles.
4. Both request in the same cycle after reset → master 0 wins first (rr_ptr=0); next contention goes to master 1.
5. m0 asserts read and write together on addr 1 → s_write=1, s_read=0; no readdatavalid.
6. Reset asserted during RDWAIT of a read → next cycle all s_*=0, waitrequest=1, and no readdatavalid is ever produced.
   - With ARB_FIXED_PRIORITY_EN defined, rerun scenario 3 → master 0 wins every time and master 1 is never accepted.
